// File: rtl/updown_button_conditioner.sv
// updown_button_conditioner
// Conditions two raw push-buttons into single-cycle step pulses for a
// downstream up/down counter. Each button is synchronized, then debounced.
// A single FSM issues one pulse per press, and optionally auto-repeats
// while one button is held. Pressing both buttons locks the FSM out until
// both buttons are released.
//
// Ports
//   clk      in   single clock, all state updates on posedge
//   rst      in   asynchronous active-high reset
//   btn_up   in   raw asynchronous up-button level (1 = pressed)
//   btn_down in   raw asynchronous down-button level (1 = pressed)
//   rep_en   in   auto-repeat enable (0 = one pulse per press)
//   increase out  registered one-cycle step-up pulse
//   decrease out  registered one-cycle step-down pulse
//   busy     out  registered, high whenever the FSM is not IDLE
module updown_button_conditioner #(
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned HOLD_CYCLES   = 1024,
  parameter int unsigned REPEAT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic rep_en,
  output logic increase,
  output logic decrease,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UP_HOLD = 3'd1,
    S_UP_REP  = 3'd2,
    S_DN_HOLD = 3'd3,
    S_DN_REP  = 3'd4,
    S_LOCK    = 3'd5
  } state_t;

  localparam logic [15:0] DB_LAST   = 16'(DB_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] REP_LAST  = 16'(REPEAT_CYCLES - 1);

  // Bit 0 carries the up button, bit 1 carries the down button.
  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  r_db;
  logic [15:0] r_db_cnt [2];

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_timer;
  logic [15:0] w_timer_nxt;
  logic        r_inc;
  logic        r_dec;
  logic        r_busy;
  logic        w_inc_nxt;
  logic        w_dec_nxt;
  logic        w_up;
  logic        w_dn;

  assign w_up     = r_db[0];
  assign w_dn     = r_db[1];
  assign increase = r_inc;
  assign decrease = r_dec;
  assign busy     = r_busy;

  // Two-flop synchronizers followed by per-button debounce counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 2'b00;
      r_sync2     <= 2'b00;
      r_db        <= 2'b00;
      r_db_cnt[0] <= 16'd0;
      r_db_cnt[1] <= 16'd0;
    end else begin
      r_sync1 <= {btn_down, btn_up};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= 16'd0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          // The count would reach DB_CYCLES on this cycle, so the level is accepted.
          r_db[i]     <= ~r_db[i];
          r_db_cnt[i] <= 16'd0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Next-state, timer and pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_inc_nxt   = 1'b0;
    w_dec_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = 16'd0;
        if (w_up && w_dn) begin
          w_state_nxt = S_LOCK;
        end else if (w_up) begin
          w_state_nxt = S_UP_HOLD;
          w_inc_nxt   = 1'b1;
        end else if (w_dn) begin
          w_state_nxt = S_DN_HOLD;
          w_dec_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_UP_HOLD, S_DN_HOLD: begin
        // The >= test saturates the timer. It also handles a timer that came
        // back from a repeat period longer than the hold period.
        if ((r_state == S_UP_HOLD) ? !w_up : !w_dn) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = 16'd0;
        end else if ((r_state == S_UP_HOLD) ? w_dn : w_up) begin
          w_state_nxt = S_LOCK;
          w_timer_nxt = 16'd0;
        end else if (r_timer >= HOLD_LAST) begin
          if (rep_en) begin
            w_state_nxt = (r_state == S_UP_HOLD) ? S_UP_REP : S_DN_REP;
            w_timer_nxt = 16'd0;
            w_inc_nxt   = (r_state == S_UP_HOLD);
            w_dec_nxt   = (r_state == S_DN_HOLD);
          end else begin
            w_timer_nxt = HOLD_LAST;
          end
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      S_UP_REP, S_DN_REP: begin
        if ((r_state == S_UP_REP) ? !w_up : !w_dn) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = 16'd0;
        end else if ((r_state == S_UP_REP) ? w_dn : w_up) begin
          w_state_nxt = S_LOCK;
          w_timer_nxt = 16'd0;
        end else if (!rep_en) begin
          // Fall back to hold with the timer frozen. No further pulses follow.
          w_state_nxt = (r_state == S_UP_REP) ? S_UP_HOLD : S_DN_HOLD;
        end else if (r_timer >= REP_LAST) begin
          w_timer_nxt = 16'd0;
          w_inc_nxt   = (r_state == S_UP_REP);
          w_dec_nxt   = (r_state == S_DN_REP);
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      S_LOCK: begin
        w_timer_nxt = 16'd0;
        if (!w_up && !w_dn) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_LOCK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = 16'd0;
      end
    endcase
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= 16'd0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_inc   <= w_inc_nxt;
      r_dec   <= w_dec_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_updown_button_conditioner.sv
module tb_updown_button_conditioner;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 8;
  localparam int unsigned REP  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic rep_en = 1'b1;
  logic increase;
  logic decrease;
  logic busy;

  typedef struct packed { int cyc; logic up; } pulse_t;
  typedef struct packed { int cyc; logic val; } busy_t;

  pulse_t exp_q[$];
  busy_t  busy_q[$];
  int     cyc;
  int     n_tests = 0;
  int     n_failed = 0;

  updown_button_conditioner #(
    .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .rep_en(rep_en), .increase(increase), .decrease(decrease), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_failed++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic exp_pulse(input int c, input logic up);
    pulse_t p;
    p.cyc = c;
    p.up  = up;
    exp_q.push_back(p);
  endtask

  task automatic exp_busy(input int c, input logic v);
    busy_t b;
    b.cyc = c;
    b.val = v;
    busy_q.push_back(b);
  endtask

  // Compares the outputs of the current cycle against the scoreboard queues.
  task automatic monitor();
    pulse_t p;
    busy_t  b;
    check("exclusive_pulses", 32'(increase & decrease), 32'd0);
    if (increase || decrease) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_failed++;
        $error("FAIL unexpected_pulse at cycle %0d: observed inc=%0b dec=%0b expected none",
               cyc, increase, decrease);
      end
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(p.cyc));
        check("pulse_is_up", 32'(increase), 32'(p.up));
      end
    end
    while (busy_q.size() != 0 && busy_q[0].cyc == cyc) begin
      b = busy_q.pop_front();
      check("busy", 32'(busy), 32'(b.val));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic start_test(input logic ren);
    rst      = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    rep_en   = ren;
    exp_q.delete();
    busy_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("reset_inc", 32'(increase), 32'd0);
    check("reset_dec", 32'(decrease), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic end_test();
    check("missing_pulses", 32'(exp_q.size()), 32'd0);
    check("missing_busy_checks", 32'(busy_q.size()), 32'd0);
  endtask

  initial begin
    // Clean up press, held 6 cycles.
    start_test(1'b1);
    exp_pulse(7, 1'b1);
    exp_busy(6, 1'b0); exp_busy(7, 1'b1); exp_busy(12, 1'b1); exp_busy(13, 1'b0);
    btn_up = 1'b1; run(6);
    btn_up = 1'b0; run(14);
    end_test();

    // Bouncing up button never settles long enough.
    start_test(1'b1);
    exp_busy(10, 1'b0); exp_busy(25, 1'b0);
    for (int k = 0; k < 10; k++) begin
      btn_up = (k % 2 == 0);
      run(2);
    end
    btn_up = 1'b0; run(12);
    end_test();

    // Down held 30 cycles with auto-repeat.
    start_test(1'b1);
    exp_pulse(7, 1'b0);
    for (int c = 15; c <= 36; c += 3) exp_pulse(c, 1'b0);
    exp_busy(36, 1'b1); exp_busy(37, 1'b0);
    btn_down = 1'b1; run(30);
    btn_down = 1'b0; run(15);
    end_test();

    // Same hold without auto-repeat: a single pulse.
    start_test(1'b0);
    exp_pulse(7, 1'b0);
    exp_busy(20, 1'b1); exp_busy(36, 1'b1); exp_busy(37, 1'b0);
    btn_down = 1'b1; run(30);
    btn_down = 1'b0; run(15);
    end_test();

    // Both buttons lock out, then a fresh down press gives one pulse.
    start_test(1'b0);
    exp_pulse(7, 1'b1);
    exp_pulse(42, 1'b0);
    exp_busy(19, 1'b1); exp_busy(31, 1'b1); exp_busy(32, 1'b0); exp_busy(34, 1'b0);
    btn_up = 1'b1; run(12);
    btn_down = 1'b1; run(13);
    btn_up = 1'b0; btn_down = 1'b0; run(10);
    btn_down = 1'b1; run(6);
    btn_down = 1'b0; run(14);
    end_test();

    // Reset in the middle of a held press cancels the pending pulse.
    start_test(1'b1);
    exp_pulse(7, 1'b1);
    exp_pulse(22, 1'b1);
    btn_up = 1'b1; run(14);
    rst = 1'b1;
    @(negedge clk);
    check("rst_inc", 32'(increase), 32'd0);
    check("rst_dec", 32'(decrease), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    run(8);
    btn_up = 1'b0; run(15);
    end_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/updown_button_conditioner.md
UPDOWN_BUTTON_CONDITIONER -- requirements
Module: updown_button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive stable synchronized samples required to change a debounced level; legal range 1..65535.
REQ-002 Parameter HOLD_CYCLES, default 1024: cycles a single button is held after its first pulse before auto-repeat starts; legal range 2..65535.
REQ-003 Parameter REPEAT_CYCLES, default 256: auto-repeat pulse period in cycles; legal range 2..65535.
REQ-004 clk  input  1  single clock, all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 btn_up  input  1  raw asynchronous up-button level, high = pressed.
REQ-007 btn_down  input  1  raw asynchronous down-button level, high = pressed.
REQ-008 rep_en  input  1  synchronous auto-repeat enable; low = one pulse per press.
REQ-009 increase  output  1  registered one-cycle step-up pulse for the downstream up/down counter.
REQ-010 decrease  output  1  registered one-cycle step-down pulse for the downstream up/down counter.
REQ-011 busy  output  1  registered, high whenever FSM is not IDLE.

Function
REQ-012 Each raw button SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per button, a 16-bit debounce counter SHALL clear whenever synchronized value equals debounced level, otherwise increment; debounced level SHALL toggle and counter clear on the cycle the counter would reach DB_CYCLES.
REQ-014 Latency: raw edge stable from cycle 0 SHALL change debounced level at end of cycle 2+DB_CYCLES-1, and the resulting pulse SHALL be high exactly during cycle 2+DB_CYCLES+1 (one cycle).
REQ-015 FSM states: IDLE, UP_HOLD, UP_REP, DN_HOLD, DN_REP, LOCK; one shared 16-bit timer.
REQ-016 IDLE: debounced up high and down low -> assert increase next cycle, go UP_HOLD, clear timer; symmetric for down -> decrease, DN_HOLD; both high -> LOCK, no pulse.
REQ-017 UP_HOLD: timer increments each cycle; timer reaching HOLD_CYCLES-1 with rep_en high -> one increase pulse, go UP_REP, clear timer; rep_en low -> timer holds at HOLD_CYCLES-1, no pulse.
REQ-018 UP_REP: timer increments; timer reaching REPEAT_CYCLES-1 -> one increase pulse, clear timer; rep_en low -> return to UP_HOLD with timer held, no further pulses.
REQ-019 DN_HOLD / DN_REP SHALL mirror REQ-017/018 using decrease.
REQ-020 In any UP_* or DN_* state: owning button debounced low -> IDLE, no pulse; other button debounced high -> LOCK, no pulse.
REQ-021 LOCK SHALL emit no pulses and exit to IDLE only when both debounced levels are low.
REQ-022 increase and decrease SHALL never be high in the same cycle; every pulse SHALL last exactly one cycle.
REQ-023 Timer SHALL never wrap; a press held indefinitely with rep_en low produces exactly one pulse.

Reset
REQ-024 rst high SHALL immediately force synchronizers, debounced levels, counters, timer to 0, state to IDLE, increase/decrease/busy to 0.
REQ-025 A button already held when rst deasserts SHALL be treated as a new press (debounced rise after DB_CYCLES), producing one pulse.
REQ-026 rst asserted mid-hold or mid-repeat SHALL cancel any pending pulse with no glitch on outputs.

Verification (bench parameters DB_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3, rep_en=1 unless stated)
REQ-027 Clean btn_up press at cycle 0 held 6 cycles -> increase high only in cycle 7, decrease never, busy returns low after release debounce.
REQ-028 btn_up bouncing 1/0 every 2 cycles for 20 cycles, then released -> zero pulses.
REQ-029 btn_down held 30 cycles -> decrease at cycle 7, then at cycle 15, then every 3 cycles (18, 21, ...) until release debounces; no increase.
REQ-030 Same hold with rep_en=0 -> exactly one decrease pulse at cycle 7.
REQ-031 btn_up held, btn_down pressed at cycle 12 -> increase at 7 only, LOCK after down debounces, no pulses until both released, then fresh btn_down press -> one decrease.
REQ-032 rst pulsed at cycle 14 during up repeat -> all outputs 0 in that cycle, no pulse at cycle 15; button still held -> next increase 7 cycles after rst deasserts.
